multilane_serial_read_buffer: RTL and testbench

Parametrised successor to the single-lane serial read buffer: deserialises a programmable number of bits from 1, 2 or 4 parallel data lanes into a right-aligned parallel word. Each word is received MSB-first or LSB-first, selected at run time. It sits behind an edge detector, which supplies a one-cycle `read_sig` strobe per external data-clock edge. It adds abort, parameter-checked counts and a busy flag to the earlier block.

---
 rtl/serial_buf_pkg.sv | 12 +
 rtl/multilane_serial_read_buffer.sv | 108 ++++++++++
 tb/tb_multilane_serial_read_buffer.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/serial_buf_pkg.sv
// serial_buf_pkg: shared types, constants and helpers for the serial read buffers
// Contents:
//   state_t     - read FSM state (IDLE, READ, DONE)
//   LEGAL_LANES - bit n is set when n lanes are supported (1, 2, 4)
//   cnt_width   - width needed to hold a bit count of 0..n
package serial_buf_pkg;
    typedef enum logic [1:0] {IDLE, READ, DONE} state_t;
    localparam logic [4:0] LEGAL_LANES = 5'b10110;
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction
endpackage

// File: rtl/multilane_serial_read_buffer.sv
// multilane_serial_read_buffer: deserialises 1/2/4 lanes into a right-aligned word, MSB- or LSB-first
// Ports:
//   sys_clk, rst_n        - clock, asynchronous active-low reset
//   start, abort          - begin / cancel a read (single-cycle)
//   read_sig, data_in     - capture strobe and LANES bits of lane data
//   lsb_first, read_count - bit order and bit count, latched on an accepted start
//   data_out              - received word, bits above read_count are 0
//   busy, done_sig, err   - read in progress / read complete pulse / illegal count pulse
module multilane_serial_read_buffer
    import serial_buf_pkg::*;
#(
    parameter int BUF_SIZE = 8,
    parameter int LANES    = 1,
    parameter int CNT_W    = cnt_width(BUF_SIZE)
) (
    input  logic                sys_clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    input  logic                read_sig,
    input  logic [LANES-1:0]    data_in,
    input  logic                lsb_first,
    input  logic [CNT_W-1:0]    read_count,
    output logic [BUF_SIZE-1:0] data_out,
    output logic                busy,
    output logic                done_sig,
    output logic                err
);
    localparam bit PARAMS_OK = (LANES >= 1) && (LANES <= 4) && (BUF_SIZE % LANES == 0)
                               && LEGAL_LANES[(LANES >= 1 && LANES <= 4) ? LANES : 0];

    if (!PARAMS_OK) begin : g_bad_params
        $error("multilane_serial_read_buffer: LANES must be 1, 2 or 4 and divide BUF_SIZE");
    end

    state_t              state_q, state_d;
    logic [BUF_SIZE-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    rc_q, rc_d;
    logic                lsb_q, lsb_d;
    logic                err_q, err_d;
    logic                idle_start;
    logic                bad_count;
    logic                last_strobe;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            rc_q    <= '0;
            lsb_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            rc_q    <= rc_d;
            lsb_q   <= lsb_d;
            err_q   <= err_d;
        end
    end

    // DONE behaves like IDLE for a new start, so a read can follow immediately
    always_comb begin
        idle_start  = start && (state_q != READ);
        bad_count   = (read_count > CNT_W'(BUF_SIZE)) || ((read_count & CNT_W'(LANES - 1)) != '0);
        last_strobe = read_sig && ((cnt_q + CNT_W'(LANES)) == rc_q);
        state_d     = IDLE;
        case (state_q)
            READ:    state_d = abort ? IDLE : (last_strobe ? DONE : READ);
            default: state_d = !idle_start ? IDLE :
                               (read_count == '0) ? DONE : (bad_count ? IDLE : READ);
        endcase
    end

    // cnt_q doubles as the LSB-first write index: both advance by LANES per strobe
    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        rc_d    = rc_q;
        lsb_d   = lsb_q;
        err_d   = 1'b0;
        if (idle_start) begin
            if (bad_count) begin
                err_d = 1'b1;
            end else begin
                shreg_d = '0;
                cnt_d   = '0;
                rc_d    = read_count;
                lsb_d   = lsb_first;
            end
        end else if (state_q == READ && abort) begin
            shreg_d = '0;
        end else if (state_q == READ && read_sig) begin
            if (lsb_q) shreg_d[cnt_q +: LANES] = data_in;
            else shreg_d = (shreg_q << LANES) | BUF_SIZE'(data_in);
            cnt_d = cnt_q + CNT_W'(LANES);
        end
    end

    always_comb begin
        data_out = shreg_q;
        busy     = (state_q == READ);
        done_sig = (state_q == DONE);
        err      = err_q;
    end
endmodule

// File: tb/tb_multilane_serial_read_buffer.sv
// tb_multilane_serial_read_buffer: 1-, 2- and 4-lane buffers checked against a group-list model
module tb_multilane_serial_read_buffer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_v[3], abort_v[3], rs_v[3], lsb_v[3];
    logic [3:0] rc_v[3], din[3];
    logic [7:0] dout[3];
    logic       busy[3], done[3], err[3];
    int         nvec = 0;
    int         nbad = 0;

    bit         act[3];
    int         need[3], ng[3];
    bit         ord[3];
    int         grp[3][8];
    logic [7:0] e_dout[3];
    bit         e_busy[3], e_done[3], e_err[3];

    always #5 clk = ~clk;

    multilane_serial_read_buffer #(.BUF_SIZE(8), .LANES(1)) dut1 (
        .sys_clk(clk), .rst_n(rst_n), .start(start_v[0]), .abort(abort_v[0]), .read_sig(rs_v[0]),
        .data_in(din[0][0:0]), .lsb_first(lsb_v[0]), .read_count(rc_v[0]),
        .data_out(dout[0]), .busy(busy[0]), .done_sig(done[0]), .err(err[0]));
    multilane_serial_read_buffer #(.BUF_SIZE(8), .LANES(2)) dut2 (
        .sys_clk(clk), .rst_n(rst_n), .start(start_v[1]), .abort(abort_v[1]), .read_sig(rs_v[1]),
        .data_in(din[1][1:0]), .lsb_first(lsb_v[1]), .read_count(rc_v[1]),
        .data_out(dout[1]), .busy(busy[1]), .done_sig(done[1]), .err(err[1]));
    multilane_serial_read_buffer #(.BUF_SIZE(8), .LANES(4)) dut4 (
        .sys_clk(clk), .rst_n(rst_n), .start(start_v[2]), .abort(abort_v[2]), .read_sig(rs_v[2]),
        .data_in(din[2][3:0]), .lsb_first(lsb_v[2]), .read_count(rc_v[2]),
        .data_out(dout[2]), .busy(busy[2]), .done_sig(done[2]), .err(err[2]));

    function automatic int lanes(input int k);
        return 1 << k;
    endfunction

    // Word value from the list of received groups: MSB-first means the earliest group is most significant
    function automatic logic [7:0] word(input int k);
        int w = 0;
        for (int j = 0; j < ng[k]; j++)
            w += grp[k][j] * (ord[k] ? (1 << (lanes(k) * j)) : (1 << (lanes(k) * (ng[k] - 1 - j))));
        return w[7:0];
    endfunction

    task automatic chk(input string nm, input int k, input logic [7:0] act_v, input logic [7:0] exp_v);
        nvec++;
        if (act_v !== exp_v) begin
            nbad++;
            $display("FAIL %s lane-cfg %0d at %0t: got %0h want %0h", nm, lanes(k), $time, act_v, exp_v);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 3; k++) begin
            if (!rst_n) begin
                act[k] = 0; ng[k] = 0; e_dout[k] = 0; e_done[k] = 0; e_err[k] = 0;
            end else begin
                e_done[k] = 0;
                e_err[k]  = 0;
                if (!act[k]) begin
                    if (start_v[k]) begin
                        if (rc_v[k] == 0) begin
                            e_dout[k] = 0;
                            e_done[k] = 1;
                        end else if (rc_v[k] > 8 || rc_v[k] % lanes(k) != 0) begin
                            e_err[k] = 1;
                        end else begin
                            act[k] = 1; need[k] = rc_v[k]; ord[k] = lsb_v[k]; ng[k] = 0; e_dout[k] = 0;
                        end
                    end
                end else if (abort_v[k]) begin
                    act[k] = 0;
                    e_dout[k] = 0;
                end else if (rs_v[k]) begin
                    grp[k][ng[k]] = int'(din[k]) % (1 << lanes(k));
                    ng[k]++;
                    e_dout[k] = word(k);
                    if (ng[k] * lanes(k) == need[k]) begin
                        act[k] = 0;
                        e_done[k] = 1;
                    end
                end
            end
            e_busy[k] = act[k];
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 3; k++) begin
                chk("data_out", k, dout[k], e_dout[k]);
                chk("busy", k, 8'(busy[k]), 8'(e_busy[k]));
                chk("done_sig", k, 8'(done[k]), 8'(e_done[k]));
                chk("err", k, 8'(err[k]), 8'(e_err[k]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input int k, input logic [3:0] rc, input logic lsb);
        rc_v[k] = rc; lsb_v[k] = lsb; start_v[k] = 1;
        tick();
        start_v[k] = 0;
    endtask

    task automatic strobe(input int k, input int v);
        din[k] = 4'(v); rs_v[k] = 1;
        tick();
        rs_v[k] = 0;
    endtask

    task automatic do_read(input int k, input logic [3:0] rc, input logic lsb, input logic [7:0] w, input logic [7:0] want);
        int n = int'(rc) / lanes(k);
        go(k, rc, lsb);
        chk("busy_after_start", k, 8'(busy[k]), 8'h01);
        for (int i = 0; i < n; i++) begin
            int j = lsb ? i : n - 1 - i;
            strobe(k, (int'(w) >> (lanes(k) * j)) % (1 << lanes(k)));
        end
        chk("lit_done", k, 8'(done[k]), 8'h01);
        chk("lit_busy", k, 8'(busy[k]), 8'h00);
        chk("lit_data", k, dout[k], want);
        tick();
        chk("lit_done_drop", k, 8'(done[k]), 8'h00);
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            start_v[k] = 0; abort_v[k] = 0; rs_v[k] = 0; lsb_v[k] = 0; rc_v[k] = 0; din[k] = 0;
        end
        repeat (3) tick();
        chk("reset_data", 0, dout[0], 8'h00);
        chk("reset_busy", 0, 8'(busy[0]), 8'h00);
        rst_n = 1;
        tick();
        do_read(0, 8, 0, 8'h3A, 8'h3A);
        do_read(0, 6, 1, 8'o52, 8'h2A);
        do_read(1, 8, 0, 8'h3A, 8'h3A);
        do_read(2, 4, 0, 8'h0F, 8'h0F);
        go(1, 5, 0);
        chk("lit_err", 1, 8'(err[1]), 8'h01);
        chk("lit_err_busy", 1, 8'(busy[1]), 8'h00);
        chk("lit_err_data", 1, dout[1], 8'h3A);
        tick();
        go(1, 0, 0);
        chk("lit_zero_done", 1, 8'(done[1]), 8'h01);
        chk("lit_zero_data", 1, dout[1], 8'h00);
        chk("lit_zero_busy", 1, 8'(busy[1]), 8'h00);
        tick();
        go(0, 6, 0);
        repeat (3) strobe(0, 1);
        abort_v[0] = 1;
        strobe(0, 1);
        abort_v[0] = 0;
        chk("lit_abort_done", 0, 8'(done[0]), 8'h00);
        chk("lit_abort_busy", 0, 8'(busy[0]), 8'h00);
        chk("lit_abort_data", 0, dout[0], 8'h00);
        tick();
        chk("lit_abort_nodone", 0, 8'(done[0]), 8'h00);
        do_read(0, 4, 0, 8'h0F, 8'h0F);
        go(0, 8, 0);
        repeat (3) strobe(0, 1);
        #2 rst_n = 0;
        #1;
        chk("lit_rst_data", 0, dout[0], 8'h00);
        chk("lit_rst_busy", 0, 8'(busy[0]), 8'h00);
        chk("lit_rst_done", 0, 8'(done[0]), 8'h00);
        tick();
        rst_n = 1;
        tick();
        go(0, 8, 0);
        for (int i = 7; i >= 4; i--) strobe(0, (8'h3A >> i) & 1);
        go(0, 2, 0);
        chk("lit_ignored_start_busy", 0, 8'(busy[0]), 8'h01);
        for (int i = 3; i >= 0; i--) begin
            chk("lit_still_busy", 0, 8'(busy[0]), 8'h01);
            strobe(0, (8'h3A >> i) & 1);
        end
        chk("lit_full_done", 0, 8'(done[0]), 8'h01);
        chk("lit_full_data", 0, dout[0], 8'h3A);
        tick();
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < 3; k++) begin
                start_v[k] = ($urandom_range(0, 7) == 0);
                abort_v[k] = ($urandom_range(0, 24) == 0);
                rs_v[k]    = ($urandom_range(0, 2) != 0);
                rc_v[k]    = 4'($urandom_range(0, 9));
                lsb_v[k]   = 1'($urandom_range(0, 1));
                din[k]     = 4'($urandom_range(0, 15));
            end
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            start_v[k] = 0; abort_v[k] = 0; rs_v[k] = 0;
        end
        repeat (2) tick();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule
